uart_case_xform: RTL
====================

Name: uart_case_xform

Overview:
- Parametrised byte-stream transform core placed between uart_rx and uart_tx; successor to the fixed upper-case converter.
- Each received byte is classified and transformed according to a run-time mode, then buffered in an internal FIFO of parametrised depth.
- Bytes are delivered through a registered valid/ready output stage.
- Overflow is accounted for with a drop counter and a sticky flag, so the host can detect lost characters.

Parameters:
DEPTH, 16, FIFO entries; power of two, at least 4
ALMOST_FULL, 12, level at or above which o_almost_full asserts; range 1..DEPTH-1
ALMOST_EMPTY, 4, XON re-enable threshold; used only with the optional feature; must be below ALMOST_FULL

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_mode  in  2  00 pass, 01 upper, 10 lower, 11 toggle case
i_rx_data  in  8  received byte
i_rx_valid  in  1  one-cycle strobe, no backpressure
i_flush  in  1  synchronous FIFO and output-stage clear
i_clr_stats  in  1  synchronous clear of o_drop_cnt and o_overflow
o_tx_data  out  8  byte to transmitter
o_tx_valid  out  1  o_tx_data valid
i_tx_ready  in  1  transmitter accepts when high with o_tx_valid
o_level  out  $clog2(DEPTH)+1  FIFO occupancy, output register excluded
o_empty  out  1  level==0
o_full  out  1  level==DEPTH
o_almost_full  out  1  level>=ALMOST_FULL
o_drop_cnt  out  8  dropped-byte count, saturates at 255
o_overflow  out  1  sticky, set on first drop

Behaviour:
- Reset (async assert, sync release) clears:
  - pointers and level to 0
  - o_tx_valid=0, o_tx_data=0x00
  - o_drop_cnt=0, o_overflow=0
  - o_empty=1, o_full=0, o_almost_full=0
- Transform is combinational on i_rx_data, using i_mode sampled in the same cycle as i_rx_valid.
  - A letter is 0x41-0x5A or 0x61-0x7A; every other byte, including those 0x80 and above, passes unchanged.
  - upper: clear bit 5 of lower-case letters.
  - lower: set bit 5 of upper-case letters.
  - toggle: invert bit 5 of letters only.
- Write: i_rx_valid in cycle N with the FIFO not full (or full with a pop in the same cycle) stores the transformed byte at the edge ending N.
- Drop: i_rx_valid while full and no pop in the same cycle drops the byte.
  - o_drop_cnt increments, saturating at 255.
  - o_overflow sets.
- Output stage: a single register.
  - Loads from the FIFO head when it is empty, or when it is transferring this cycle (o_tx_valid and i_tx_ready).
  - A load is a pop.
  - Back-to-back transfers sustain one byte per cycle.
- Latency: rx strobe in cycle N -> o_tx_valid high in N+2 when the FIFO and stage are empty.
- Handshake: while o_tx_valid=1 and i_tx_ready=0, o_tx_data holds stable and o_tx_valid stays high.
- Simultaneous write and pop: level is unchanged; when level==0 the written byte is not popped in the same cycle.
- Pointers wrap modulo DEPTH.
- Level and flags are registered and updated at the same edge as the pointers.
- i_flush:
  - clears pointers, level and o_tx_valid at the next edge, abandoning any pending byte.
  - A write in the flush cycle is discarded and does not count as a drop.
  - Counters are kept.
- i_clr_stats: clears the counter and the flag.
  - If a drop occurs in the same cycle, the result is cnt=1, flag=1.
- Mode change mid-stream affects only bytes strobed after the change.

Optional Feature:
Macro CASE_XFORM_XONXOFF_EN.
- Defined: adds a flow FSM with states ON, SEND_XOFF, OFF, SEND_XON; reset state is ON.
  - ON -> SEND_XOFF when level>=ALMOST_FULL.
  - SEND_XOFF -> OFF when 0x13 is loaded into the output stage.
  - OFF -> SEND_XON when level<=ALMOST_EMPTY.
  - SEND_XON -> ON when 0x11 is loaded.
  - In SEND_* states the control byte has priority over the FIFO head at the next output-stage load.
  - Control bytes are never popped from the FIFO and never transformed.
  - i_flush forces SEND_XON if the state is OFF or SEND_XOFF.
- Undefined: no FSM, and the output stage loads only from the FIFO.
- Port list is identical in both builds.

Test Plan:
- mode=01, strobe "a","Z","{","7" -> tx sequence 0x41,0x5A,0x7B,0x37; first o_tx_valid two cycles after the first strobe.
- mode=11, strobe 0x61,0x41,0xE1 -> 0x41,0x61,0xE1; mode=00 -> bytes unchanged; mode=10, "Q" -> 0x71.
- i_tx_ready=0, strobe 18 bytes with DEPTH=16 -> o_full=1, level=16; output stage holds byte 1; 17th byte stays in the FIFO; 18th is dropped, giving o_drop_cnt=1 and o_overflow=1. Release ready -> 17 bytes out in order, one per cycle.
- Full FIFO with i_tx_ready=1 and a strobe in the same cycle -> no drop, level stays 16; then i_clr_stats -> cnt=0, flag=0.
- Hold i_tx_ready low for 5 cycles with valid high -> o_tx_data stable. Assert i_rst_n low mid-stream -> all outputs immediately at reset values.
- XONXOFF build: fill to 12 -> 0x13 emitted before the queued data; drain to 4 -> 0x11 emitted; i_flush while OFF -> next output 0x11.

Source files
------------

// File: rtl/uart_case_xform.sv
// uart_case_xform: case-transforming byte FIFO with a registered valid/ready output stage and drop accounting.
// Optional XON/XOFF flow control is enabled by defining CASE_XFORM_XONXOFF_EN.
module uart_case_xform #(
  parameter int DEPTH        = 16,
  parameter int ALMOST_FULL  = 12,
  parameter int ALMOST_EMPTY = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [1:0]               i_mode,
  input  logic [7:0]               i_rx_data,
  input  logic                     i_rx_valid,
  input  logic                     i_flush,
  input  logic                     i_clr_stats,
  output logic [7:0]               o_tx_data,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_almost_full,
  output logic [7:0]               o_drop_cnt,
  output logic                     o_overflow
);
  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 4 || (1 << AW) != DEPTH) begin : g_depth_chk
    $error("DEPTH must be a power of two and at least 4");
  end
  if (ALMOST_FULL < 1 || ALMOST_FULL >= DEPTH || ALMOST_EMPTY >= ALMOST_FULL) begin : g_thr_chk
    $error("threshold parameters out of range");
  end

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   lvl_n;
  logic [7:0]    xf;
  logic          is_up, is_lo;
  logic          can_load, load, load_ctrl, pop, wr, drop;
  logic          send;
  logic [7:0]    ctrl_byte;

  always_comb begin
    is_up = i_rx_data >= 8'h41 && i_rx_data <= 8'h5A;
    is_lo = i_rx_data >= 8'h61 && i_rx_data <= 8'h7A;
    xf = i_mode == 2'b01 && is_lo ? i_rx_data & 8'hDF :
         i_mode == 2'b10 && is_up ? i_rx_data | 8'h20 :
         i_mode == 2'b11 && (is_up || is_lo) ? i_rx_data ^ 8'h20 : i_rx_data;
  end

  // Control bytes take the load slot ahead of the FIFO head and are never popped.
  always_comb begin
    can_load  = (!o_tx_valid || i_tx_ready) && !i_flush;
    load_ctrl = can_load && send;
    pop       = can_load && !send && !o_empty;
    load      = load_ctrl || pop;
    wr        = i_rx_valid && !i_flush && (!o_full || pop);
    drop      = i_rx_valid && !i_flush && o_full && !pop;
    lvl_n     = o_level + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
  end

  always_ff @(posedge i_clk) begin
    if (wr) mem[wr_ptr] <= xf;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      o_level       <= '0;
      o_empty       <= 1'b1;
      o_full        <= 1'b0;
      o_almost_full <= 1'b0;
    end else if (i_flush) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      o_level       <= '0;
      o_empty       <= 1'b1;
      o_full        <= 1'b0;
      o_almost_full <= 1'b0;
    end else begin
      wr_ptr        <= wr ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr        <= pop ? rd_ptr + 1'b1 : rd_ptr;
      o_level       <= lvl_n;
      o_empty       <= lvl_n == '0;
      o_full        <= int'(lvl_n) == DEPTH;
      o_almost_full <= int'(lvl_n) >= ALMOST_FULL;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_tx_data  <= 8'h00;
      o_tx_valid <= 1'b0;
    end else if (i_flush) begin
      o_tx_valid <= 1'b0;
    end else if (load) begin
      o_tx_data  <= load_ctrl ? ctrl_byte : mem[rd_ptr];
      o_tx_valid <= 1'b1;
    end else if (i_tx_ready) begin
      o_tx_valid <= 1'b0;
    end
  end

  // A drop coinciding with a stats clear is still counted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_drop_cnt <= 8'h00;
      o_overflow <= 1'b0;
    end else if (i_clr_stats) begin
      o_drop_cnt <= {7'd0, drop};
      o_overflow <= drop;
    end else if (drop) begin
      o_drop_cnt <= o_drop_cnt == 8'hFF ? 8'hFF : o_drop_cnt + 8'd1;
      o_overflow <= 1'b1;
    end
  end

`ifdef CASE_XFORM_XONXOFF_EN
  typedef enum logic [1:0] {FL_ON, FL_SEND_XOFF, FL_OFF, FL_SEND_XON} fl_t;
  fl_t state, state_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= FL_ON;
    else state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (i_flush)
      state_n = state == FL_OFF || state == FL_SEND_XOFF ? FL_SEND_XON : state;
    else
      case (state)
        FL_ON:        state_n = int'(o_level) >= ALMOST_FULL ? FL_SEND_XOFF : FL_ON;
        FL_SEND_XOFF: state_n = load_ctrl ? FL_OFF : FL_SEND_XOFF;
        FL_OFF:       state_n = int'(o_level) <= ALMOST_EMPTY ? FL_SEND_XON : FL_OFF;
        default:      state_n = load_ctrl ? FL_ON : FL_SEND_XON;
      endcase
  end

  always_comb begin
    send      = state == FL_SEND_XOFF || state == FL_SEND_XON;
    ctrl_byte = state == FL_SEND_XOFF ? 8'h13 : 8'h11;
  end
`else
  always_comb begin
    send      = 1'b0;
    ctrl_byte = 8'h00;
  end
`endif
endmodule
